// File: rtl/dcache_access_unit_if.sv
// Word-wide memory port between the data-cache access unit (master) and memory (slave).
// A transaction completes on the clock edge where mem_req and mem_ready are both high.
interface dcache_access_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WORD_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic [WORD_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/dcache_access_unit.sv
// Memory-stage data-cache sequencer: word/byte loads and stores on a word-wide req/ready port,
// byte stores as read-modify-write, sign-extended byte loads, pipeline stall until completion.
module dcache_access_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  d_cache_access,
    input  logic                  d_cache_op,
    input  logic                  is_byte_op,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] store_data,
    dcache_access_unit_if.master  mem,
    output logic [WORD_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  misaligned,
    output logic                  stall
);
    localparam int unsigned LANE_W = 2;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RMW_READ,
        RMW_WRITE,
        DONE
    } state_t;

    state_t              state;
    logic [LANE_W-1:0]   lane_q;
    logic [BYTE_W-1:0]   byte_q;
    logic                is_byte_q;

    logic [4:0]            bit_idx_c;
    logic [BYTE_W-1:0]     rd_byte_c;
    logic [WORD_WIDTH-1:0] merged_c;

    // Byte lane selection and merge use the lane latched at accept, not the live address.
    always_comb begin
        bit_idx_c = {lane_q, 3'b000};
        rd_byte_c = mem.mem_rdata[bit_idx_c +: BYTE_W];
        merged_c  = mem.mem_rdata;
        merged_c[bit_idx_c +: BYTE_W] = byte_q;
    end

    assign stall = (state == IDLE && d_cache_access) ||
                   (state inside {READ, WRITE, RMW_READ, RMW_WRITE});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            lane_q        <= '0;
            byte_q        <= '0;
            is_byte_q     <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            load_data     <= '0;
            load_valid    <= 1'b0;
            misaligned    <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_cache_access) begin
                        lane_q    <= addr[LANE_W-1:0];
                        byte_q    <= store_data[BYTE_W-1:0];
                        is_byte_q <= is_byte_op;
                        if (!is_byte_op && addr[LANE_W-1:0] != 2'b00) begin
                            misaligned <= 1'b1;
                            state      <= DONE;
                        end else begin
                            mem.mem_req  <= 1'b1;
                            mem.mem_addr <= {addr[ADDR_WIDTH-1:LANE_W], 2'b00};
                            if (d_cache_op) begin
                                mem.mem_we <= 1'b0;
                                state      <= READ;
                            end else if (is_byte_op) begin
                                mem.mem_we <= 1'b0;
                                state      <= RMW_READ;
                            end else begin
                                mem.mem_we    <= 1'b1;
                                mem.mem_wdata <= store_data;
                                state         <= WRITE;
                            end
                        end
                    end
                end
                READ: begin
                    if (mem.mem_ready) begin
                        mem.mem_req <= 1'b0;
                        load_valid  <= 1'b1;
                        load_data   <= is_byte_q
                                     ? {{(WORD_WIDTH-BYTE_W){rd_byte_c[BYTE_W-1]}}, rd_byte_c}
                                     : mem.mem_rdata;
                        state       <= DONE;
                    end
                end
                WRITE: begin
                    if (mem.mem_ready) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        state       <= DONE;
                    end
                end
                // Read data turns straight around into the write; mem_req stays high.
                RMW_READ: begin
                    if (mem.mem_ready) begin
                        mem.mem_we    <= 1'b1;
                        mem.mem_wdata <= merged_c;
                        state         <= RMW_WRITE;
                    end
                end
                RMW_WRITE: begin
                    if (mem.mem_ready) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/dcache_access_unit.md
Name: dcache_access_unit

Overview:
- Memory-stage responder for the data-cache control signals produced by decode: `d_cache_access`, `d_cache_op` (1 = load, 0 = store) and `is_byte_op`.
- Sequences word and byte loads/stores onto a word-wide memory port with a req/ready handshake, and stalls the pipeline until the access completes.
- Byte stores are performed as read-modify-write.
- Byte loads return a sign-extended byte.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- WORD_WIDTH, 32, data word width (fixed 4 byte lanes, little-endian).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- d_cache_access  in  1  memory-stage request valid; held stable by the pipeline while stall=1
- d_cache_op  in  1  1 = load, 0 = store
- is_byte_op  in  1  1 = byte access, 0 = word access
- addr  in  ADDR_WIDTH  byte address
- store_data  in  WORD_WIDTH  store source; byte store uses bits [7:0]
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write, registered
- mem_addr  out  ADDR_WIDTH  word-aligned address (addr with bits [1:0] = 0), registered
- mem_wdata  out  WORD_WIDTH  write data, registered
- mem_rdata  in  WORD_WIDTH  read data, valid when mem_ready=1 on a read
- mem_ready  in  1  completes the current transaction on this edge
- load_data  out  WORD_WIDTH  load result, registered
- load_valid  out  1  one-cycle pulse, in DONE, for loads only
- misaligned  out  1  one-cycle pulse, in DONE, for word access with addr[1:0] != 0
- stall  out  1  freeze upstream pipeline (combinational)

Behaviour:
- Reset (async, any state, including mid-transaction):
  - state = IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, load_data, load_valid and misaligned all go to 0 immediately.
  - Any outstanding memory transaction is abandoned.
  - After reset the memory must tolerate mem_req dropping without ready.
- States: IDLE, READ, WRITE, RMW_READ, RMW_WRITE, DONE.
- IDLE with d_cache_access=1 (accept edge):
  - Word access with addr[1:0] != 0 → DONE with misaligned=1. No mem_req is issued; load_data is unchanged.
  - Word load → READ: mem_req=1, mem_we=0.
  - Byte load → READ: mem_req=1, mem_we=0.
  - Word store → WRITE: mem_req=1, mem_we=1, mem_wdata=store_data.
  - Byte store → RMW_READ: mem_req=1, mem_we=0.
- Handshake:
  - mem_req, mem_addr, mem_we and mem_wdata are held constant until an edge where mem_req=1 and mem_ready=1.
  - mem_ready is ignored while mem_req=0.
  - No new request is issued before the previous one completes.
- READ completes:
  - load_data = mem_rdata for a word load.
  - For a byte load: lane = addr[1:0], byte = mem_rdata[8*lane+7 : 8*lane], load_data = that byte sign-extended to WORD_WIDTH.
  - Next state DONE with load_valid=1.
- WRITE completes → DONE. mem_req=0.
- RMW_READ completes:
  - Next state RMW_WRITE, with mem_req kept 1 (back-to-back, no idle cycle) and mem_we=1.
  - mem_wdata = mem_rdata with byte lane addr[1:0] replaced by store_data[7:0]; all other lanes are preserved.
- RMW_WRITE completes → DONE.
- DONE:
  - Lasts exactly one cycle, then → IDLE.
  - stall=0, so the pipeline advances on this edge.
  - Any d_cache_access seen in DONE belongs to the finished instruction and is ignored (one-cycle bubble between accesses).
  - load_valid and misaligned are 0 in every state except DONE.
- stall = 1 when (state = IDLE and d_cache_access=1) or state ∈ {READ, WRITE, RMW_READ, RMW_WRITE}; otherwise 0.
- Latency with mem_ready tied high:
  - Word load / word store: 2 stall cycles, then DONE.
  - Byte store: 3 stall cycles.
  - Misaligned access: 1 stall cycle.
- d_cache_op and is_byte_op are don't-care when d_cache_access=0. No memory activity occurs in IDLE without a request.
- If the request inputs change while stall=1 (a protocol violation), the behaviour is undefined. The unit latches addr[1:0] and store_data[7:0] at accept, so the in-flight access completes using the latched values.

Test Plan:
- Word load, addr=0x100, mem_ready=1 the cycle after accept, mem_rdata=0xDEADBEEF → mem_addr=0x100, mem_we=0; stall high 2 cycles; DONE: load_valid=1, load_data=0xDEADBEEF.
- Byte load, addr=0x103, mem_rdata=0x80FF1234 → load_data=0xFFFFFF80. Repeat with addr=0x101 → 0x00000012.
- Byte store, addr=0x202, store_data=0xAB, RMW read returns 0x11223344 → second transaction mem_we=1, mem_addr=0x200, mem_wdata=0x11AB3344; stall 3 cycles; load_valid stays 0.
- Word store, addr=0x10, store_data=0xCAFEF00D, mem_ready delayed 4 cycles → mem_req/mem_addr/mem_wdata stable for all 4 wait cycles; exactly one write; stall deasserts only in DONE.
- Misaligned word load, addr=0x6 → no mem_req ever; misaligned=1 for one cycle; load_valid=0; stall high 1 cycle.
- Reset asserted mid RMW_WRITE while mem_ready=0 → mem_req, stall and all outputs 0 immediately (asynchronously, without waiting for a clock edge); after release, a new word load completes normally.
